// File: rtl/axi_rr_arbiter_pkg.sv
// Shared AXI3 field widths, burst encodings and FSM state types for the
// read/write arbiter and its round-robin picker.
package axi_rr_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;
  localparam int ID_W    = 4;
  // Outstanding read counter width; holds MAX_OUTST up to 15.
  localparam int CNT_W   = 4;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP = 2'b10;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_RESP   = 2'd2
  } w_state_e;

  // Width of an index into n masters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter_pick.sv
// Round-robin picker: returns the first asserted request at or after ptr_i,
// wrapping around, as both a one-hot vector and an index.
module rr_pick
  import axi_rr_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req_i,
  input  logic [idx_w(N)-1:0] ptr_i,
  output logic [N-1:0]        gnt_oh_o,
  output logic [idx_w(N)-1:0] gnt_idx_o,
  output logic                gnt_valid_o
);

  localparam int IW = idx_w(N);

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = IW'(idx);
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// AXI3 arbiter: round-robin read address grant with id tagging and
// rid-based read data return, bounded outstanding reads, and fully
// serialised writes (one owner holds AW/W/B until its B handshake).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid never depends on ready; ready may depend on valid.
module axi_rr_arbiter
  import axi_rr_arbiter_pkg::*;
#(
  parameter int                 NUM_RD    = 2,
  parameter int                 NUM_WR    = 2,
  parameter int                 MAX_OUTST = 4,
  parameter logic [BURST_W-1:0] BURST     = BURST_INCR
) (
  input  logic                        clk,
  input  logic                        rst,
  // per-master read side
  input  logic [NUM_RD*ADDR_W-1:0]    m_araddr,
  input  logic [NUM_RD*LEN_W-1:0]     m_arlen,
  input  logic [NUM_RD*SIZE_W-1:0]    m_arsize,
  input  logic [NUM_RD-1:0]           m_arvalid,
  output logic [NUM_RD-1:0]           m_arready,
  output logic [NUM_RD*DATA_W-1:0]    m_rdata,
  output logic [NUM_RD*RESP_W-1:0]    m_rresp,
  output logic [NUM_RD-1:0]           m_rlast,
  output logic [NUM_RD-1:0]           m_rvalid,
  input  logic [NUM_RD-1:0]           m_rready,
  // per-master write side
  input  logic [NUM_WR*ADDR_W-1:0]    m_awaddr,
  input  logic [NUM_WR*LEN_W-1:0]     m_awlen,
  input  logic [NUM_WR*SIZE_W-1:0]    m_awsize,
  input  logic [NUM_WR-1:0]           m_awvalid,
  output logic [NUM_WR-1:0]           m_awready,
  input  logic [NUM_WR*DATA_W-1:0]    m_wdata,
  input  logic [NUM_WR*STRB_W-1:0]    m_wstrb,
  input  logic [NUM_WR-1:0]           m_wlast,
  input  logic [NUM_WR-1:0]           m_wvalid,
  output logic [NUM_WR-1:0]           m_wready,
  output logic [NUM_WR*RESP_W-1:0]    m_bresp,
  output logic [NUM_WR-1:0]           m_bvalid,
  input  logic [NUM_WR-1:0]           m_bready,
  // bus AR
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [LEN_W-1:0]            arlen,
  output logic [SIZE_W-1:0]           arsize,
  output logic [BURST_W-1:0]          arburst,
  output logic [LOCK_W-1:0]           arlock,
  output logic [CACHE_W-1:0]          arcache,
  output logic [PROT_W-1:0]           arprot,
  output logic                        arvalid,
  input  logic                        arready,
  // bus R
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [RESP_W-1:0]           rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  // bus AW
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [LEN_W-1:0]            awlen,
  output logic [SIZE_W-1:0]           awsize,
  output logic [BURST_W-1:0]          awburst,
  output logic [LOCK_W-1:0]           awlock,
  output logic [CACHE_W-1:0]          awcache,
  output logic [PROT_W-1:0]           awprot,
  output logic                        awvalid,
  input  logic                        awready,
  // bus W
  output logic [ID_W-1:0]             wid,
  output logic [DATA_W-1:0]           wdata,
  output logic [STRB_W-1:0]           wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  // bus B
  input  logic [ID_W-1:0]             bid,
  input  logic [RESP_W-1:0]           bresp,
  input  logic                        bvalid,
  output logic                        bready,
  // state visibility
  output logic                        dbg_ar_state_o,
  output logic [1:0]                  dbg_w_state_o,
  output logic [CNT_W-1:0]            dbg_rd_cnt_o
);

  localparam int RIW = idx_w(NUM_RD);
  localparam int WIW = idx_w(NUM_WR);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  ar_state_e        ar_state_q, ar_state_d;
  logic [RIW-1:0]   ar_gnt_q, ar_gnt_d;
  logic [RIW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  w_state_e         w_state_q, w_state_d;
  logic [WIW-1:0]   w_own_q, w_own_d;
  logic [WIW-1:0]   wr_ptr_q, wr_ptr_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [NUM_RD-1:0] rd_oh_unused;
  logic [RIW-1:0]    rd_idx;
  logic              rd_req_valid;
  logic [NUM_WR-1:0] wr_oh_unused;
  logic [WIW-1:0]    wr_idx;
  logic              wr_req_valid;

  logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;
  logic unused_bid;

  // The bus B id is not needed: only the current write owner can be waiting.
  assign unused_bid = ^bid;

  rr_pick #(.N(NUM_RD)) u_rd_pick (
    .req_i       (m_arvalid),
    .ptr_i       (rd_ptr_q),
    .gnt_oh_o    (rd_oh_unused),
    .gnt_idx_o   (rd_idx),
    .gnt_valid_o (rd_req_valid)
  );

  rr_pick #(.N(NUM_WR)) u_wr_pick (
    .req_i       (m_awvalid),
    .ptr_i       (wr_ptr_q),
    .gnt_oh_o    (wr_oh_unused),
    .gnt_idx_o   (wr_idx),
    .gnt_valid_o (wr_req_valid)
  );

  assign ar_hs     = arvalid & arready;
  assign r_last_hs = rvalid & rready & rlast;
  assign aw_hs     = awvalid & awready;
  assign w_last_hs = wvalid & wready & wlast;
  assign b_hs      = bvalid & bready;

  assign dbg_ar_state_o = ar_state_q;
  assign dbg_w_state_o  = w_state_q;
  assign dbg_rd_cnt_o   = cnt_q;

  // State registers for both channels; reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_state_q <= AR_IDLE;
      ar_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      w_state_q  <= W_IDLE;
      w_own_q    <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_gnt_q   <= ar_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      w_state_q  <= w_state_d;
      w_own_q    <= w_own_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // AR grant FSM: grant is registered in IDLE and held until the AR handshake.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_gnt_d   = ar_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (ar_state_q)
      AR_IDLE: begin
        if (rd_req_valid && (cnt_q < MAX_CNT)) begin
          ar_gnt_d   = rd_idx;
          ar_state_d = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (ar_hs) begin
          rd_ptr_d   = (ar_gnt_q == RIW'(NUM_RD - 1)) ? '0 : ar_gnt_q + 1'b1;
          ar_state_d = AR_IDLE;
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  // Outstanding read bursts: up on AR accept, down on a final read beat.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && !r_last_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!ar_hs && r_last_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Bus AR driven from the granted master; only that master sees arready.
  always_comb begin
    arid      = ID_W'(ar_gnt_q);
    araddr    = m_araddr[int'(ar_gnt_q)*ADDR_W +: ADDR_W];
    arlen     = m_arlen[int'(ar_gnt_q)*LEN_W +: LEN_W];
    arsize    = m_arsize[int'(ar_gnt_q)*SIZE_W +: SIZE_W];
    arvalid   = (ar_state_q == AR_BUSY) && m_arvalid[ar_gnt_q];
    m_arready = '0;
    if (ar_state_q == AR_BUSY) begin
      m_arready[ar_gnt_q] = arready;
    end
  end

  assign arburst = BURST;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  // R return by rid; unknown ids are accepted and dropped so the bus never stalls.
  always_comb begin
    logic hit;
    hit      = 1'b0;
    rready   = 1'b0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rid == ID_W'(i)) begin
        hit                          = 1'b1;
        m_rvalid[i]                  = rvalid;
        m_rdata[i*DATA_W +: DATA_W]  = rdata;
        m_rresp[i*RESP_W +: RESP_W]  = rresp;
        m_rlast[i]                   = rlast;
        rready                       = rvalid & m_rready[i];
      end
    end
    if (!hit) begin
      rready = rvalid;
    end
  end

  // Write ownership FSM: AW and W run concurrently, B closes the transaction.
  always_comb begin
    w_state_d = w_state_q;
    w_own_d   = w_own_q;
    wr_ptr_d  = wr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_req_valid) begin
          w_own_d   = wr_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (aw_hs)     aw_done_d = 1'b1;
        if (w_last_hs) w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_ptr_d  = (w_own_q == WIW'(NUM_WR - 1)) ? '0 : w_own_q + 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Bus AW/W/B connected to the write owner only; each channel closes once done.
  always_comb begin
    logic active, resp;
    active    = (w_state_q == W_ACTIVE);
    resp      = (w_state_q == W_RESP);
    awid      = ID_W'(w_own_q);
    awaddr    = m_awaddr[int'(w_own_q)*ADDR_W +: ADDR_W];
    awlen     = m_awlen[int'(w_own_q)*LEN_W +: LEN_W];
    awsize    = m_awsize[int'(w_own_q)*SIZE_W +: SIZE_W];
    awvalid   = active && !aw_done_q && m_awvalid[w_own_q];
    wid       = ID_W'(w_own_q);
    wdata     = m_wdata[int'(w_own_q)*DATA_W +: DATA_W];
    wstrb     = m_wstrb[int'(w_own_q)*STRB_W +: STRB_W];
    wlast     = m_wlast[w_own_q];
    wvalid    = active && !w_done_q && m_wvalid[w_own_q];
    bready    = resp && m_bready[w_own_q];
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_awready[w_own_q] = active && !aw_done_q && awready;
    m_wready[w_own_q]  = active && !w_done_q && wready;
    m_bvalid[w_own_q]  = resp && bvalid;
    if (resp) begin
      m_bresp[int'(w_own_q)*RESP_W +: RESP_W] = bresp;
    end
  end

  assign awburst = BURST;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

endmodule
